bus_alu_stage: RTL and testbench

//  Multi-cycle execute stage that consumes the 16-bit operand bus driven by the operand multiplexer.

---
 rtl/bus_alu_stage.sv | 190 +++++++++++++++++++
 tb/tb_bus_alu_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_alu_stage.sv
// Multi-cycle execute stage: collects A then B from the operand bus, computes into G.
// Single-cycle ALU ops complete in OPB; MUL iterates one shift-add step per cycle.
module bus_alu_stage #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] g_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPB,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [2:0]         op_q, op_d;
    logic [SHAMT_W-1:0] step_q, step_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic [WIDTH-1:0]   alu_g;
    logic               alu_c, alu_v;
    logic [WIDTH:0]     sum, dif, shl, shr;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   mul_acc;
    logic               wr_res;

    // B is taken straight from the bus so single-cycle ops finish in OPB
    always_comb begin
        shamt = bus_in[SHAMT_W-1:0];
        sum   = {1'b0, a_q} + {1'b0, bus_in};
        dif   = {1'b0, a_q} - {1'b0, bus_in};
        shl   = {1'b0, a_q} << shamt;
        shr   = {a_q, 1'b0} >> shamt;
        alu_g = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_g = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a_q[WIDTH-1] == bus_in[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_g = dif[WIDTH-1:0];
                alu_c = dif[WIDTH];
                alu_v = (a_q[WIDTH-1] != bus_in[WIDTH-1]) &&
                        (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_g = a_q & bus_in;
            OP_OR:  alu_g = a_q | bus_in;
            OP_XOR: alu_g = a_q ^ bus_in;
            OP_SLL: begin
                alu_g = shl[WIDTH-1:0];
                alu_c = shl[WIDTH];
            end
            OP_SRL: begin
                alu_g = shr[WIDTH:1];
                alu_c = shr[0];
            end
            default: alu_g = '0;
        endcase
    end

    always_comb begin
        mul_acc = acc_q;
        if (b_q[step_q]) begin
            mul_acc = acc_q + (a_q << step_q);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        acc_d   = acc_q;
        op_d    = op_q;
        step_d  = step_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        wr_res  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = bus_in;
                    op_d    = op;
                    state_d = S_OPB;
                end
            end
            S_OPB: begin
                b_d = bus_in;
                if (op_q == OP_MUL) begin
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = S_MUL;
                end else begin
                    g_d     = alu_g;
                    c_d     = alu_c;
                    v_d     = alu_v;
                    wr_res  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                acc_d  = mul_acc;
                step_d = step_q + 1'b1;
                if (step_q == LAST) begin
                    g_d     = mul_acc;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    wr_res  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_res) begin
            z_d = (g_d == '0);
            n_d = g_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            step_q  <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            step_q  <= step_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign busy   = (state_q == S_OPB) || (state_q == S_MUL);
    assign done   = (state_q == S_DONE);
    assign g_out  = g_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_bus_alu_stage.sv
// Randomized bench for bus_alu_stage against an arithmetic reference model.
// Covers directed corner cases, ignored starts and mid-MUL reset.
module tb_bus_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        start;
    logic [2:0]  op;
    logic        busy, done;
    logic [15:0] g_out;
    logic        flag_z, flag_n, flag_c, flag_v;

    int n_tests = 0;
    int n_fail  = 0;

    bus_alu_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_in (bus_in),
        .start  (start),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .g_out  (g_out),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // returns G and {Z,N,C,V}
    function automatic void model(input logic [2:0] o, input int unsigned a,
                                  input int unsigned b, output int unsigned g,
                                  output logic [3:0] f);
        int unsigned r, s, c, v;
        c = 0;
        v = 0;
        r = 0;
        s = b % 16;
        case (o)
            3'd0: begin
                r = a + b;
                c = r >> 16;
                r = r & 32'hFFFF;
                v = ((a >> 15) == (b >> 15)) && ((r >> 15) != (a >> 15));
            end
            3'd1: begin
                r = (a - b) & 32'hFFFF;
                c = (a < b) ? 1 : 0;
                v = ((a >> 15) != (b >> 15)) && ((r >> 15) != (a >> 15));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = (a << s) & 32'hFFFF;
                c = (s != 0) ? ((a >> (16 - s)) & 1) : 0;
            end
            3'd6: begin
                r = a >> s;
                c = (s != 0) ? ((a >> (s - 1)) & 1) : 0;
            end
            default: r = (a * b) & 32'hFFFF;
        endcase
        g = r;
        f = {(r == 0), r[15], c[0], v[0]};
    endfunction

    task automatic run_op(input logic [2:0] o, input int unsigned a,
                          input int unsigned b, input bit poke_mul,
                          input bit poke_done);
        int unsigned eg;
        logic [3:0]  ef;
        int          n;
        int          busy_cnt;
        int          lat;
        model(o, a, b, eg, ef);
        lat = (o == 3'd7) ? 17 : 1;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        bus_in = a[15:0];
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bus_in = b[15:0];
        op     = 3'($urandom);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            n++;
            bus_in = 16'($urandom);
            if (poke_mul && n == 5) begin
                start = 1'b1;
                op    = o ^ 3'b001;
            end else begin
                start = 1'b0;
            end
        end
        check("latency", n, lat);
        check("busy_cycles", busy_cnt, lat);
        check("g", g_out, eg);
        check("flags", {flag_z, flag_n, flag_c, flag_v}, ef);
        if (poke_done) begin
            start  = 1'b1;
            op     = o ^ 3'b001;
            bus_in = 16'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("g_hold", g_out, eg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          seen;
        logic [2:0]  ro;
        int unsigned ra, rb;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        bus_in = 16'h0;
        #12;
        check("rst_g", g_out, 0);
        check("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'h7FFF, 32'h0001, 0, 0);
        run_op(3'd1, 32'h0003, 32'h0005, 0, 0);
        run_op(3'd1, 32'h8000, 32'h0001, 0, 0);
        run_op(3'd5, 32'h8001, 32'h0001, 0, 0);
        run_op(3'd6, 32'h0003, 32'h0010, 0, 0);
        run_op(3'd7, 32'h0123, 32'h0010, 0, 0);
        run_op(3'd7, 32'hFFFF, 32'hFFFF, 1, 1);
        run_op(3'd0, 32'hFFFF, 32'h0001, 0, 1);
        run_op(3'd5, 32'h1234, 32'h000F, 0, 0);
        run_op(3'd6, 32'h8000, 32'h000F, 0, 0);

        // abort a MUL part way through
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd7;
        bus_in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bus_in = 16'h00FF;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_g", g_out, 0);
        check("abort_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        run_op(3'd7, 32'h0003, 32'h0007, 0, 0);

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom & 32'hFFFF;
            rb = $urandom & 32'hFFFF;
            if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h7FFF;
            if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF : 32'h0000;
            run_op(ro, ra, rb, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
